// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: default geometry, arbiter state type and
// the reference x/y-to-linear-address mapping for a 640-pixel-wide screen.
package fb_pkg;

    localparam int H_RES_DEF  = 640;
    localparam int V_RES_DEF  = 480;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 19;
    localparam int FB_WORDS   = H_RES_DEF * V_RES_DEF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_e;

    // y*640 + x as (y<<9) + (y<<7) + x, so no multiplier is needed.
    function automatic logic [ADDR_W_DEF-1:0] xy_to_addr(input logic [9:0] x,
                                                         input logic [9:0] y);
        logic [ADDR_W_DEF-1:0] yw;
        logic [ADDR_W_DEF-1:0] xw;
        yw = {9'b0_0000_0000, y};
        xw = {9'b0_0000_0000, x};
        return (yw << 9) + (yw << 7) + xw;
    endfunction

endpackage

// File: rtl/fb_xy_to_addr.sv
// Combinational pixel-coordinate to framebuffer-address translation with an
// in-range flag; the 640-wide geometry uses the package shift-add mapping.
module fb_xy_to_addr
    import fb_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              in_range_o
);

    generate
        if (H_RES == 640 && ADDR_W == ADDR_W_DEF) begin : g_shift_add
            assign addr_o = xy_to_addr(x_i, y_i);
        end else begin : g_const_mult
            assign addr_o = ADDR_W'(y_i) * ADDR_W'(H_RES) + ADDR_W'(x_i);
        end
    endgenerate

    assign in_range_o = ({1'b0, x_i} < 11'(H_RES)) && ({1'b0, y_i} < 11'(V_RES));

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: video fetch always wins the RAM slot,
// clear-screen fill and host writes share whatever cycles fetch leaves free.
module fb_access_arbiter
    import fb_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk_50mhz,
    input  logic              i_n_reset,
    input  logic              i_fetch_req,
    input  logic [9:0]        i_fetch_x,
    input  logic [9:0]        i_fetch_y,
    output logic              o_fetch_valid,
    output logic [DATA_W-1:0] o_fetch_data,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [9:0]        i_wr_x,
    input  logic [9:0]        i_wr_y,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_clear_start,
    input  logic [DATA_W-1:0] i_clear_color,
    output logic              o_clear_busy,
    output logic              o_clear_done,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fv1_q, fv2_q, fir1_q, fir2_q;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;

    logic [ADDR_W-1:0] fetch_addr_s;
    logic              fetch_in_range_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic              wr_in_range_s;
    logic              fetch_hit_s;
    logic              wr_ready_s;
    logic              wr_issue_s;

    fb_xy_to_addr #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_fetch_map (
        .x_i        (i_fetch_x),
        .y_i        (i_fetch_y),
        .addr_o     (fetch_addr_s),
        .in_range_o (fetch_in_range_s)
    );

    fb_xy_to_addr #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_wr_map (
        .x_i        (i_wr_x),
        .y_i        (i_wr_y),
        .addr_o     (wr_addr_s),
        .in_range_o (wr_in_range_s)
    );

    assign fetch_hit_s = i_fetch_req && fetch_in_range_s;
    assign wr_ready_s  = (state_q == ST_IDLE) && !i_fetch_req;
    // Out-of-range writes still handshake but never reach the RAM.
    assign wr_issue_s  = i_wr_valid && wr_ready_s && wr_in_range_s;

    // Slot arbitration, fill sequencing and fetch return next-state logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        color_d       = color_q;
        addr_d        = addr_q;
        we_d          = 1'b0;
        wdata_d       = wdata_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        fetch_valid_d = fv2_q;
        fetch_data_d  = fetch_data_q;

        if (fetch_hit_s) begin
            addr_d = fetch_addr_s;
        end else if (state_q == ST_CLEAR) begin
            we_d    = 1'b1;
            addr_d  = cnt_q;
            wdata_d = color_q;
        end else if (wr_issue_s) begin
            we_d    = 1'b1;
            addr_d  = wr_addr_s;
            wdata_d = i_wr_data;
        end else begin
            we_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                    color_d = i_clear_color;
                    busy_d  = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (fetch_hit_s) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = {ADDR_W{1'b0}};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Stage 2 carries the request whose RAM read data is on i_mem_rdata now.
        if (fv2_q) begin
            fetch_data_d = fir2_q ? i_mem_rdata : {DATA_W{1'b0}};
        end else begin
            fetch_data_d = fetch_data_q;
        end
    end

    // All state and output registers; reset abandons any fill silently.
    always_ff @(posedge i_clk_50mhz or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {ADDR_W{1'b0}};
            color_q       <= {DATA_W{1'b0}};
            addr_q        <= {ADDR_W{1'b0}};
            we_q          <= 1'b0;
            wdata_q       <= {DATA_W{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fv1_q         <= 1'b0;
            fv2_q         <= 1'b0;
            fir1_q        <= 1'b0;
            fir2_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            color_q       <= color_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fv1_q         <= i_fetch_req;
            fir1_q        <= fetch_hit_s;
            fv2_q         <= fv1_q;
            fir2_q        <= fir1_q;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
        end
    end

    assign o_wr_ready    = wr_ready_s;
    assign o_mem_addr    = addr_q;
    assign o_mem_we      = we_q;
    assign o_mem_wdata   = wdata_q;
    assign o_clear_busy  = busy_q;
    assign o_clear_done  = done_q;
    assign o_fetch_valid = fetch_valid_q;
    assign o_fetch_data  = fetch_data_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed + randomized bench for fb_access_arbiter with a behavioural
// framebuffer/arbiter reference model and a simple 1-cycle RAM.
module tb_fb_access_arbiter;

    localparam int H = 640;
    localparam int V = 24;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [9:0]  fx = 10'd0, fy = 10'd0;
    logic        wr_valid = 1'b0;
    logic [9:0]  wx = 10'd0, wy = 10'd0;
    logic [7:0]  wd = 8'd0;
    logic        clr_start = 1'b0;
    logic [7:0]  clr_color = 8'd0;
    logic        o_fetch_valid, o_wr_ready, o_clear_busy, o_clear_done, o_mem_we;
    logic [7:0]  o_fetch_data, o_mem_wdata, ram_q;
    logic [18:0] o_mem_addr;

    fb_access_arbiter #(.H_RES(H), .V_RES(V), .DATA_W(8), .ADDR_W(19)) dut (
        .i_clk_50mhz(clk), .i_n_reset(rst_n),
        .i_fetch_req(fetch_req), .i_fetch_x(fx), .i_fetch_y(fy),
        .o_fetch_valid(o_fetch_valid), .o_fetch_data(o_fetch_data),
        .i_wr_valid(wr_valid), .o_wr_ready(o_wr_ready),
        .i_wr_x(wx), .i_wr_y(wy), .i_wr_data(wd),
        .i_clear_start(clr_start), .i_clear_color(clr_color),
        .o_clear_busy(o_clear_busy), .o_clear_done(o_clear_done),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(ram_q)
    );

    always #10 clk = ~clk;

    // Synchronous single-port RAM with one cycle of read latency.
    logic [7:0] ram [0:N-1];
    always @(posedge clk) begin
        if (o_mem_we && o_mem_addr < 19'(N)) ram[o_mem_addr] <= o_mem_wdata;
        ram_q <= (o_mem_addr < 19'(N)) ? ram[o_mem_addr] : 8'h00;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pixel contents, fill progress and expected outputs.
    bit [7:0]    mm [0:N-1];
    bit          mk [0:N-1];
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    bit [7:0]    m_col = 8'd0;
    bit          e_we = 1'b0, e_done = 1'b0;
    bit [18:0]   e_addr = 19'd0;
    bit [7:0]    e_wd = 8'd0;
    bit          pa_v = 1'b0, pb_v = 1'b0, po_v = 1'b0;
    bit          pa_k = 1'b0, pb_k = 1'b0, po_k = 1'b0;
    bit [7:0]    pa_d = 8'd0, pb_d = 8'd0, po_d = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_cnt = 0;
        e_we = 1'b0; e_done = 1'b0; e_addr = 19'd0; e_wd = 8'd0;
        pa_v = 1'b0; pb_v = 1'b0; po_v = 1'b0;
    endtask

    // Apply current inputs for one clock and compare every output to the model.
    task automatic step();
        bit fin, acc, was_busy;
        int fa, wa;
        #1;
        chk("wr_ready", 32'(o_wr_ready), 32'(!m_busy && !fetch_req));
        was_busy = m_busy;
        fin = fetch_req && (int'(fx) < H) && (int'(fy) < V);
        fa  = int'(fy) * H + int'(fx);
        wa  = int'(wy) * H + int'(wx);
        acc = wr_valid && !m_busy && !fetch_req && (int'(wx) < H) && (int'(wy) < V);
        po_v = pb_v; po_k = pb_k; po_d = pb_d;
        pb_v = pa_v; pb_k = pa_k; pb_d = pa_d;
        pa_v = fetch_req;
        pa_k = fin ? mk[fa] : 1'b1;
        pa_d = fin ? mm[fa] : 8'h00;
        e_done = 1'b0;
        if (fin) begin
            e_we = 1'b0; e_addr = 19'(fa);
        end else if (m_busy) begin
            e_we = 1'b1; e_addr = 19'(m_cnt); e_wd = m_col;
            mm[m_cnt] = m_col; mk[m_cnt] = 1'b1;
            if (m_cnt == N - 1) begin
                m_busy = 1'b0; e_done = 1'b1;
            end else begin
                m_cnt++;
            end
        end else if (acc) begin
            e_we = 1'b1; e_addr = 19'(wa); e_wd = wd;
            mm[wa] = wd; mk[wa] = 1'b1;
        end else begin
            e_we = 1'b0;
        end
        if (!was_busy && clr_start) begin
            m_busy = 1'b1; m_cnt = 0; m_col = clr_color;
        end
        @(posedge clk); #1;
        chk("mem_we", 32'(o_mem_we), 32'(e_we));
        chk("mem_addr", 32'(o_mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(o_mem_wdata), 32'(e_wd));
        chk("clear_busy", 32'(o_clear_busy), 32'(m_busy));
        chk("clear_done", 32'(o_clear_done), 32'(e_done));
        chk("fetch_valid", 32'(o_fetch_valid), 32'(po_v));
        if (po_v && po_k) chk("fetch_data", 32'(o_fetch_data), 32'(po_d));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, 32'(o_mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(o_mem_wdata), 32'd0);
        chk({tag, "_fv"}, 32'(o_fetch_valid), 32'd0);
        chk({tag, "_fd"}, 32'(o_fetch_data), 32'd0);
        chk({tag, "_busy"}, 32'(o_clear_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_clear_done), 32'd0);
    endtask

    int busy_cyc, fin_cnt, fill_we, done_cnt;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        model_reset();

        // Preload (1,1)=A5 through the host port
        wr_valid = 1'b1; wx = 10'd1; wy = 10'd1; wd = 8'hA5;
        step();
        chk("preload_addr", 32'(o_mem_addr), 32'd641);
        wr_valid = 1'b0;

        // Fetch latency: address after k, data only after k+2
        fetch_req = 1'b1; fx = 10'd1; fy = 10'd1;
        step();
        chk("lat_addr", 32'(o_mem_addr), 32'd641);
        fetch_req = 1'b0;
        step();
        chk("lat_early_valid", 32'(o_fetch_valid), 32'd0);
        step();
        chk("lat_data", 32'(o_fetch_data), 32'hA5);

        // Out-of-range fetch returns zero, no RAM access
        fetch_req = 1'b1; fx = 10'd640; fy = 10'd0;
        step();
        fetch_req = 1'b0;
        step(); step();
        chk("oor_fetch_valid", 32'(o_fetch_valid), 32'd1);

        // Fetch blocks host writes
        fetch_req = 1'b1; fx = 10'd7; fy = 10'd2;
        wr_valid = 1'b1; wx = 10'd3; wy = 10'd2; wd = 8'h77;
        repeat (4) step();
        fetch_req = 1'b0;
        step();
        chk("prio_wr_addr", 32'(o_mem_addr), 32'd1283);
        wr_valid = 1'b0;

        // Out-of-range writes handshake but never write
        wr_valid = 1'b1; wx = 10'd0; wy = 10'd480;
        step();
        wy = 10'(V);
        step();
        wr_valid = 1'b0;
        step(); step();

        // Randomized fetch/write traffic around the screen corners
        for (int i = 0; i < 400; i++) begin
            fetch_req = ($urandom_range(0, 2) == 0);
            fx = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(636, 645)) : 10'($urandom_range(0, 7));
            fy = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(V - 2, V + 1)) : 10'($urandom_range(0, 3));
            wr_valid = $urandom_range(0, 1) == 1;
            wx = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(636, 645)) : 10'($urandom_range(0, 7));
            wy = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(V - 2, V + 1)) : 10'($urandom_range(0, 3));
            wd = 8'($urandom);
            step();
        end
        fetch_req = 1'b0; wr_valid = 1'b0;
        step(); step();

        // Reset in the middle of a fill
        clr_start = 1'b1; clr_color = 8'h5A;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 2000 && m_cnt < 1000; i++) step();
        #4 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step();

        // Full clear with a fetch every other cycle
        busy_cyc = 0; fin_cnt = 0; fill_we = 0; done_cnt = 0;
        clr_start = 1'b1; clr_color = 8'h3C;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 3 * N && m_busy; i++) begin
            fetch_req = i[0];
            fx = 10'($urandom_range(0, H + 3));
            fy = 10'($urandom_range(0, V + 1));
            if (fetch_req && int'(fx) < H && int'(fy) < V) fin_cnt++;
            if (o_clear_busy) busy_cyc++;
            step();
            if (o_mem_we) fill_we++;
            if (o_clear_done) done_cnt++;
        end
        fetch_req = 1'b0;
        step();
        if (o_clear_done) done_cnt++;
        chk("fill_finished", 32'(o_clear_busy), 32'd0);
        chk("fill_writes", 32'(fill_we), 32'(N));
        chk("fill_busy_cycles", 32'(busy_cyc), 32'(N + fin_cnt));
        chk("fill_done_pulses", 32'(done_cnt), 32'd1);

        // Simultaneous start, write and fetch; second start ignored
        fetch_req = 1'b1; fx = 10'd2; fy = 10'd0;
        wr_valid = 1'b1; wx = 10'd5; wy = 10'd5; wd = 8'h11;
        clr_start = 1'b1; clr_color = 8'h77;
        step();
        chk("sim_fetch_addr", 32'(o_mem_addr), 32'd2);
        fetch_req = 1'b0; clr_color = 8'hEE;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 2 * N && m_busy; i++) step();
        chk("sim_fill_finished", 32'(o_clear_busy), 32'd0);
        step();
        chk("sim_late_write", 32'(o_mem_addr), 32'(5 * H + 5));
        wr_valid = 1'b0;
        fetch_req = 1'b1; fx = 10'd5; fy = 10'd5;
        step();
        fx = 10'd6;
        step();
        fetch_req = 1'b0;
        step();
        chk("sim_read_write", 32'(o_fetch_data), 32'h11);
        step();
        chk("sim_read_fill", 32'(o_fetch_data), 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
